// File: rtl/shift_block.sv
// Eight-stage serial delay line built from two cascaded SIPO registers.
// X holds the newest WIDTH samples of D; Y holds the WIDTH samples before those.
module shift_block #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             D,
  output logic [WIDTH-1:0] X,
  output logic [WIDTH-1:0] Y
);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  // Right shift: new sample enters at the MSB; Y is fed from the bit leaving X.
  always_comb begin
    x_d = {D, x_q[WIDTH-1:1]};
    y_d = {x_q[0], y_q[WIDTH-1:1]};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign X = x_q;
  assign Y = y_q;

endmodule

// File: tb/tb_shift_block.sv
// Directed and random checks of shift_block against an 8-sample history model.
module tb_shift_block;

  localparam int unsigned WIDTH = 4;

  logic             Clk;
  logic             Rst;
  logic             D;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;

  int unsigned errors;
  int unsigned checks;

  // hist[7] is the newest sample; upper nibble is X, lower nibble is Y
  logic [2*WIDTH-1:0] hist;
  logic [2*WIDTH-1:0] exp_q[$];

  shift_block #(.WIDTH(WIDTH)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .D   (D),
    .X   (X),
    .Y   (Y)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check_vec(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the falling edge, predict, then compare after the rising edge.
  task automatic step(input logic rst, input logic d, input string tag);
    logic [2*WIDTH-1:0] e;
    @(negedge Clk);
    Rst = rst;
    D   = d;
    if (rst) hist = '0;
    else     hist = {d, hist[2*WIDTH-1:1]};
    exp_q.push_back(hist);
    @(posedge Clk);
    #1;
    e = exp_q.pop_front();
    check_vec({tag, ".X"}, X, e[2*WIDTH-1:WIDTH]);
    check_vec({tag, ".Y"}, Y, e[WIDTH-1:0]);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hist   = '0;
    Rst    = 1'b1;
    D      = 1'b1;

    step(1'b1, 1'b1, "reset0");
    step(1'b1, 1'b1, "reset1");

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "fill");
    check_vec("fill_const.X", X, 4'b1111);
    check_vec("fill_const.Y", Y, 4'b0000);

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, "cascade");
    check_vec("cascade_const.Y", Y, 4'b1111);

    step(1'b1, 1'b0, "alt_rst");
    step(1'b0, 1'b1, "alt");
    step(1'b0, 1'b0, "alt");
    step(1'b0, 1'b1, "alt");
    step(1'b0, 1'b0, "alt");
    step(1'b0, 1'b1, "alt");
    check_vec("alt_const.X", X, 4'b1010);
    check_vec("alt_const.Y", Y, 4'b1000);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "refill");
    step(1'b1, 1'b1, "mid_rst");
    check_vec("mid_rst_const.X", X, 4'b0000);
    step(1'b0, 1'b1, "post_rst");
    check_vec("post_rst_const.X", X, 4'b1000);
    check_vec("post_rst_const.Y", Y, 4'b0000);

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, "flush");
    check_vec("flush_const.Y", Y, 4'b0000);

    for (int i = 0; i < 40; i++)
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
